// File: rtl/handshake_constant_seq.sv
// Elastic constant source: each accepted control token emits entries from a
// compile-time table, one entry per token (step) or the whole table (burst).
module handshake_constant_seq #(
    parameter int                          DATA_WIDTH = 32,
    parameter int                          DEPTH      = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0] VALUES     = '0,
    parameter int                          MODE       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  outs_last
);
    localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic                    load_en;
    logic                    produce;
    logic [IDX_W-1:0]        sel_idx;
    logic [IDX_W-1:0]        next_idx;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   entry;

    always_comb begin
        load_en    = !outs_valid || outs_ready;
        ctrl_ready = 1'b0;
        produce    = 1'b0;
        sel_idx    = idx;
        if (MODE == 0) begin
            ctrl_ready = rst && load_en;
            produce    = ctrl_valid && ctrl_ready;
        end else if (state == IDLE) begin
            // A burst always starts at entry 0, whatever idx holds.
            ctrl_ready = rst && load_en;
            produce    = ctrl_valid && ctrl_ready;
            sel_idx    = '0;
        end else begin
            produce    = load_en;
        end
        sel_last = (sel_idx == LAST_IDX);
        next_idx = sel_last ? '0 : sel_idx + 1'b1;
        entry    = VALUES[DATA_WIDTH*int'(sel_idx) +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            outs       <= '0;
            outs_valid <= 1'b0;
            outs_last  <= 1'b0;
        end else begin
            if (load_en) begin
                outs_valid <= produce;
                if (produce) begin
                    outs      <= entry;
                    outs_last <= sel_last;
                end
            end
            if (produce) begin
                idx <= next_idx;
                // Burst mode leaves IDLE unless the entry just loaded ends the table.
                state <= (MODE != 0 && !sel_last) ? BURST : IDLE;
            end
        end
    end
endmodule

// File: tb/tb_handshake_constant_seq.sv
// Directed bench for handshake_constant_seq: step mode, burst mode and a
// single-entry burst instance, all sharing one clock and reset.
module tb_handshake_constant_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       s_ctrl_valid = 0, s_ctrl_ready, s_outs_valid, s_outs_ready = 0, s_outs_last;
    logic [7:0] s_outs;
    logic       b_ctrl_valid = 0, b_ctrl_ready, b_outs_valid, b_outs_ready = 0, b_outs_last;
    logic [7:0] b_outs;
    logic       o_ctrl_valid = 0, o_ctrl_ready, o_outs_valid, o_outs_ready = 0, o_outs_last;
    logic [7:0] o_outs;

    logic [7:0] tbl [3] = '{8'h11, 8'h22, 8'h33};

    handshake_constant_seq #(.DATA_WIDTH(8), .DEPTH(3), .VALUES(24'h332211), .MODE(0)) u_step (
        .clk(clk), .rst(rst), .ctrl_valid(s_ctrl_valid), .ctrl_ready(s_ctrl_ready),
        .outs(s_outs), .outs_valid(s_outs_valid), .outs_ready(s_outs_ready), .outs_last(s_outs_last));

    handshake_constant_seq #(.DATA_WIDTH(8), .DEPTH(3), .VALUES(24'h332211), .MODE(1)) u_burst (
        .clk(clk), .rst(rst), .ctrl_valid(b_ctrl_valid), .ctrl_ready(b_ctrl_ready),
        .outs(b_outs), .outs_valid(b_outs_valid), .outs_ready(b_outs_ready), .outs_last(b_outs_last));

    handshake_constant_seq #(.DATA_WIDTH(8), .DEPTH(1), .VALUES(8'hA5), .MODE(1)) u_one (
        .clk(clk), .rst(rst), .ctrl_valid(o_ctrl_valid), .ctrl_ready(o_ctrl_ready),
        .outs(o_outs), .outs_valid(o_outs_valid), .outs_ready(o_outs_ready), .outs_last(o_outs_last));

    // Leaves time at posedge+1 with reset released and all tokens idle.
    task automatic do_reset();
        s_ctrl_valid = 0; b_ctrl_valid = 0; o_ctrl_valid = 0;
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        s_ctrl_valid = 1; b_ctrl_valid = 1; o_ctrl_valid = 1;
        s_outs_ready = 1; b_outs_ready = 1; o_outs_ready = 1;
        @(posedge clk); #1;
        total++; if ({s_outs_valid, s_outs_last, s_outs} !== 10'h0) begin bad++;
            $display("FAIL reset_step got v=%b l=%b d=%h want 0", s_outs_valid, s_outs_last, s_outs); end
        total++; if ({b_outs_valid, b_outs_last, b_outs} !== 10'h0) begin bad++;
            $display("FAIL reset_burst got v=%b l=%b d=%h want 0", b_outs_valid, b_outs_last, b_outs); end
        total++; if ({o_outs_valid, o_outs_last, o_outs} !== 10'h0) begin bad++;
            $display("FAIL reset_one got v=%b l=%b d=%h want 0", o_outs_valid, o_outs_last, o_outs); end
        total++; if ({s_ctrl_ready, b_ctrl_ready, o_ctrl_ready} !== 3'b000) begin bad++;
            $display("FAIL reset_ctrl_ready got %b want 000", {s_ctrl_ready, b_ctrl_ready, o_ctrl_ready}); end
        do_reset();
    endtask

    task automatic test_step_back_to_back();
        logic [7:0] exp [5] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22};
        do_reset();
        s_outs_ready = 1;
        s_ctrl_valid = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (s_ctrl_ready !== 1'b1) begin bad++;
                $display("FAIL step_b2b_ready[%0d] got %b want 1", i, s_ctrl_ready); end
            @(posedge clk); #1;
            total++; if (s_outs_valid !== 1'b1 || s_outs !== exp[i] || s_outs_last !== (i == 2)) begin bad++;
                $display("FAIL step_b2b_item[%0d] got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         i, s_outs_valid, s_outs, s_outs_last, exp[i], (i == 2)); end
        end
        s_ctrl_valid = 0;
        @(posedge clk); #1;
        total++; if (s_outs_valid !== 1'b0) begin bad++;
            $display("FAIL step_b2b_drain got v=%b want 0", s_outs_valid); end
    endtask

    task automatic test_step_backpressure();
        do_reset();
        s_outs_ready = 0;
        s_ctrl_valid = 1;
        @(posedge clk); #1;
        total++; if (s_outs_valid !== 1'b1 || s_outs !== 8'h11) begin bad++;
            $display("FAIL step_bp_first got v=%b d=%h want v=1 d=11", s_outs_valid, s_outs); end
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (s_ctrl_ready !== 1'b0) begin bad++;
                $display("FAIL step_bp_ready[%0d] got %b want 0", i, s_ctrl_ready); end
            @(posedge clk); #1;
            total++; if (s_outs_valid !== 1'b1 || s_outs !== 8'h11 || s_outs_last !== 1'b0) begin bad++;
                $display("FAIL step_bp_hold[%0d] got v=%b d=%h l=%b want v=1 d=11 l=0",
                         i, s_outs_valid, s_outs, s_outs_last); end
        end
        s_outs_ready = 1;
        #1;
        total++; if (s_ctrl_ready !== 1'b1) begin bad++;
            $display("FAIL step_bp_release_ready got %b want 1", s_ctrl_ready); end
        @(posedge clk); #1;
        total++; if (s_outs_valid !== 1'b1 || s_outs !== 8'h22) begin bad++;
            $display("FAIL step_bp_next got v=%b d=%h want v=1 d=22", s_outs_valid, s_outs); end
        s_ctrl_valid = 0;
        @(posedge clk); #1;
        total++; if (s_outs_valid !== 1'b0) begin bad++;
            $display("FAIL step_bp_drain got v=%b want 0", s_outs_valid); end
    endtask

    task automatic test_burst_two();
        logic       exp_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] exp_d   [6] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};
        do_reset();
        b_outs_ready = 1;
        b_ctrl_valid = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (b_ctrl_ready !== exp_rdy[i]) begin bad++;
                $display("FAIL burst2_ready[%0d] got %b want %b", i, b_ctrl_ready, exp_rdy[i]); end
            @(posedge clk); #1;
            total++; if (b_outs_valid !== 1'b1 || b_outs !== exp_d[i] || b_outs_last !== (i % 3 == 2)) begin bad++;
                $display("FAIL burst2_item[%0d] got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         i, b_outs_valid, b_outs, b_outs_last, exp_d[i], (i % 3 == 2)); end
            if (i == 3) b_ctrl_valid = 0;
        end
        @(posedge clk); #1;
        total++; if (b_outs_valid !== 1'b0) begin bad++;
            $display("FAIL burst2_drain got v=%b want 0", b_outs_valid); end
    endtask

    task automatic test_burst_random();
        int         tokens = 0;
        int         items  = 0;
        int         cyc    = 0;
        logic       stalled;
        logic [7:0] held;
        logic       held_last;
        do_reset();
        b_ctrl_valid = 1;
        while (items < 60 && cyc < 2000) begin
            b_outs_ready = 1'($urandom_range(0, 1));
            #1;
            stalled   = b_outs_valid && !b_outs_ready;
            held      = b_outs;
            held_last = b_outs_last;
            if (b_outs_valid && b_outs_ready) begin
                total++; if (b_outs !== tbl[items % 3] || b_outs_last !== (items % 3 == 2)) begin bad++;
                    $display("FAIL burst_rand_item[%0d] got d=%h l=%b want d=%h l=%b",
                             items, b_outs, b_outs_last, tbl[items % 3], (items % 3 == 2)); end
                items++;
            end
            if (b_ctrl_valid && b_ctrl_ready) tokens++;
            @(posedge clk); #1;
            cyc++;
            if (stalled) begin
                total++; if (b_outs_valid !== 1'b1 || b_outs !== held || b_outs_last !== held_last) begin bad++;
                    $display("FAIL burst_rand_stall cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             cyc, b_outs_valid, b_outs, b_outs_last, held, held_last); end
            end
            if (tokens == 20) b_ctrl_valid = 0;
        end
        total++; if (items != 60 || tokens != 20) begin bad++;
            $display("FAIL burst_rand_count got items=%0d tokens=%0d want items=60 tokens=20", items, tokens); end
        b_outs_ready = 1;
        @(posedge clk); #1;
        total++; if (b_outs_valid !== 1'b0) begin bad++;
            $display("FAIL burst_rand_extra got v=%b want 0", b_outs_valid); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        b_outs_ready = 1;
        b_ctrl_valid = 1;
        @(posedge clk); #1;
        b_ctrl_valid = 0;
        @(posedge clk); #1;
        total++; if (b_outs_valid !== 1'b1 || b_outs !== 8'h22) begin bad++;
            $display("FAIL midrst_pre got v=%b d=%h want v=1 d=22", b_outs_valid, b_outs); end
        #1 rst = 0;
        #1;
        total++; if ({b_outs_valid, b_outs_last, b_outs, b_ctrl_ready} !== 11'h0) begin bad++;
            $display("FAIL midrst_async got v=%b l=%b d=%h r=%b want all 0",
                     b_outs_valid, b_outs_last, b_outs, b_ctrl_ready); end
        @(posedge clk); #1;
        rst = 1;
        b_ctrl_valid = 1;
        #1;
        total++; if (b_ctrl_ready !== 1'b1) begin bad++;
            $display("FAIL midrst_ready got %b want 1", b_ctrl_ready); end
        @(posedge clk); #1;
        b_ctrl_valid = 0;
        total++; if (b_outs_valid !== 1'b1 || b_outs !== 8'h11 || b_outs_last !== 1'b0) begin bad++;
            $display("FAIL midrst_first got v=%b d=%h l=%b want v=1 d=11 l=0", b_outs_valid, b_outs, b_outs_last); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_depth_one();
        do_reset();
        o_outs_ready = 1;
        o_ctrl_valid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (o_ctrl_ready !== 1'b1) begin bad++;
                $display("FAIL one_ready[%0d] got %b want 1", i, o_ctrl_ready); end
            @(posedge clk); #1;
            total++; if (o_outs_valid !== 1'b1 || o_outs !== 8'hA5 || o_outs_last !== 1'b1) begin bad++;
                $display("FAIL one_item[%0d] got v=%b d=%h l=%b want v=1 d=a5 l=1",
                         i, o_outs_valid, o_outs, o_outs_last); end
        end
        o_outs_ready = 0;
        #1;
        total++; if (o_ctrl_ready !== 1'b0) begin bad++;
            $display("FAIL one_stall_ready got %b want 0", o_ctrl_ready); end
        @(posedge clk); #1;
        total++; if (o_outs_valid !== 1'b1 || o_outs !== 8'hA5) begin bad++;
            $display("FAIL one_stall_hold got v=%b d=%h want v=1 d=a5", o_outs_valid, o_outs); end
        o_outs_ready = 1;
        o_ctrl_valid = 0;
        @(posedge clk); #1;
        total++; if (o_outs_valid !== 1'b0) begin bad++;
            $display("FAIL one_drain got v=%b want 0", o_outs_valid); end
    endtask

    initial begin
        #2;
        test_reset();
        test_step_back_to_back();
        test_step_backpressure();
        test_burst_two();
        test_burst_random();
        test_reset_mid_burst();
        test_depth_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/handshake_constant_seq.md
# handshake_constant_seq

Parametrised elastic constant source for the dataflow handshake fabric. Each control token accepted on the `ctrl` channel triggers emission of compile-time constants from a packed table, either one entry per token with a wrapping pointer or a full table burst per token. The output is registered, so `outs_valid` and `outs` never depend combinationally on `ctrl_valid`. The block sits wherever a kernel needs a coefficient table, replay pattern or loop-bound sequence gated by a control token.

## Interface
- `DATA_WIDTH`, 32, width of each constant.
- `DEPTH`, 4, number of table entries; legal range is DEPTH ≥ 1.
- `VALUES`, 0, packed table of DEPTH*DATA_WIDTH bits; entry i = `VALUES[i*DATA_WIDTH +: DATA_WIDTH]`.
- `MODE`, 0, 0 = step mode (one entry per token), 1 = burst mode (DEPTH entries per token).
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `ctrl_valid`  input  1  control token present.
- `ctrl_ready`  output  1  control token accepted this cycle when high together with `ctrl_valid`.
- `outs`  output  DATA_WIDTH  registered constant.
- `outs_valid`  output  1  `outs` holds a valid item.
- `outs_ready`  input  1  downstream accepts.
- `outs_last`  output  1  item is table entry DEPTH-1, meaning end of table or end of burst.

## Operation
- The one-entry output register holds `outs`, `outs_valid` and `outs_last`. `load_en = !outs_valid || outs_ready`. The register loads only when `load_en` is high and a new item is produced.
- Index register `idx` is max(1, clog2(DEPTH)) bits. It wraps from DEPTH-1 to 0.
- `outs_last` is 1 exactly when the loaded entry index equals DEPTH-1.
- When `load_en` is high and no item is produced, `outs_valid` goes to 0. `outs` keeps its last value.
- Step mode (MODE=0):
  - `ctrl_ready = load_en`.
  - On a ctrl fire, load entry `idx` and advance `idx` with wrap.
  - `idx` persists across tokens. Successive tokens get entries 0,1,…,DEPTH-1,0,…
- Burst mode (MODE=1) uses an FSM with states IDLE and BURST.
  - IDLE: `ctrl_ready = load_en`. On a ctrl fire, load entry 0.
    - If DEPTH==1: set `outs_last`=1 and stay in IDLE.
    - Otherwise: set `idx`=1 and go to BURST.
  - BURST: `ctrl_ready = 0`. On each `load_en`, load entry `idx`.
    - If `idx`==DEPTH-1: set `idx`=0 and go to IDLE.
    - Otherwise: increment `idx`.
  - Tokens offered during BURST are stalled, not dropped.
- Simultaneous `outs` fire and `ctrl` fire in the same cycle: the register reloads. No bubble and no loss.
- Reset takes effect immediately and asynchronously, including mid-burst:
  - `outs_valid`=0, `outs`=0, `outs_last`=0, `idx`=0, state=IDLE.
  - `ctrl_ready`=0 while `rst` is low.
  - The first token after reset receives entry 0.

## Timing
- Latency from ctrl fire (edge N) to `outs_valid` high is 1 cycle: the item is visible after edge N.
- Throughput is one item per cycle while `outs_ready` is held high, in both modes.
- Burst mode: a DEPTH-entry burst occupies DEPTH consecutive cycles at full throughput. A new token is accepted in the same cycle the last entry is loaded? No: it is accepted on the cycle after, when the FSM is back in IDLE.
  - Burst-to-burst gap is therefore at most 1 cycle with no output bubble beyond it.
- Backpressure:
  - `outs`, `outs_valid` and `outs_last` remain stable while `outs_valid && !outs_ready`.
  - `ctrl_ready` is low in that condition.
- `ctrl_ready` depends combinationally on `outs_ready`, `outs_valid` and state. It never depends on `ctrl_valid`.

## Test plan
Common bench setup: DATA_WIDTH=8, DEPTH=3, VALUES=24'h332211, so entries are 0x11, 0x22, 0x33.
- Step mode, `outs_ready`=1, 5 back-to-back tokens -> `outs` = 11,22,33,11,22. `outs_last` is high on the 33 only. Each item appears 1 cycle after its token.
- Step mode, `outs_ready`=0 for 4 cycles after the first token -> `outs`=11 held stable and `ctrl_ready`=0. On release, the next token yields 22 with no loss.
- Burst mode, 2 tokens presented continuously -> `outs` = 11,22,33, then 11,22,33, with `outs_last` on each 33. `ctrl_ready`=0 during the BURST cycles. Second token accepted the cycle after the first 33 loads.
- Burst mode, random `outs_ready` (50%) over 20 tokens -> the scoreboard sees exact repeating 11,22,33 groups, no duplicates or drops, and stable outputs under stall.
- Reset asserted asynchronously mid-burst after 22 -> outputs go to 0 without waiting for a clock edge. After release, the next token yields 11.
- Burst mode with DEPTH=1, VALUES=8'hA5 -> every token yields A5 with `outs_last`=1. `ctrl_ready` follows `load_en` and the FSM never enters BURST.
